// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/coordinate generator driven by a pixel-tick enable,
// with active-area blanking and built-in test patterns on registered outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] red_in,
  input  logic [CW-1:0] green_in,
  input  logic [CW-1:0] blue_in,
  output logic [10:0]   x,
  output logic [10:0]   y,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);
  localparam logic [10:0]   H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0]   V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0]   H_ACT_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   V_ACT_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0]   HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt_r;
  logic [10:0]   h_cnt_r;
  logic [10:0]   v_cnt_r;
  logic [BW-1:0] bar_pos_r;
  logic [2:0]    bar_idx_r;
  logic [1:0]    mode_q_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          de_r;
  logic          frame_start_r;
  logic [CW-1:0] red_r;
  logic [CW-1:0] green_r;
  logic [CW-1:0] blue_r;

  logic          tick_s;
  logic          h_wrap_s;
  logic          origin_s;
  logic          active_s;
  logic          hs_on_s;
  logic          vs_on_s;
  logic          edge_s;
  logic          grid_s;
  logic [1:0]    mode_s;
  logic [CW-1:0] red_s;
  logic [CW-1:0] green_s;
  logic [CW-1:0] blue_s;

  assign tick_s   = (div_cnt_r == DIV_LAST);
  assign h_wrap_s = (h_cnt_r == H_LAST);
  assign origin_s = (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
  assign active_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
  assign hs_on_s  = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
  assign vs_on_s  = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
  assign edge_s   = (h_cnt_r == 11'd0) || (h_cnt_r == H_ACT_LAST) ||
                    (v_cnt_r == 11'd0) || (v_cnt_r == V_ACT_LAST);
  assign grid_s   = (h_cnt_r[3:0] == 4'd0) || (v_cnt_r[3:0] == 4'd0) ||
                    (h_cnt_r == H_ACT_LAST) || (v_cnt_r == V_ACT_LAST);

  // Pixel-tick divider: free-running 0..CLK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // Raster counters, bar tracker and frame-aligned mode latch; only move on a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r   <= 11'd0;
      v_cnt_r   <= 11'd0;
      bar_pos_r <= '0;
      bar_idx_r <= 3'd0;
      mode_q_r  <= 2'b00;
    end else if (tick_s) begin
      if (origin_s) begin
        mode_q_r <= mode;
      end else begin
        mode_q_r <= mode_q_r;
      end
      if (h_wrap_s) begin
        h_cnt_r   <= 11'd0;
        bar_pos_r <= '0;
        bar_idx_r <= 3'd0;
        if (v_cnt_r == V_LAST) begin
          v_cnt_r <= 11'd0;
        end else begin
          v_cnt_r <= v_cnt_r + 11'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 11'd1;
        // bar index tracks h_cnt/BAR_W incrementally instead of dividing
        if (bar_pos_r == BAR_LAST) begin
          bar_pos_r <= '0;
          bar_idx_r <= bar_idx_r + 3'd1;
        end else begin
          bar_pos_r <= bar_pos_r + BW'(1);
        end
      end
    end else begin
      h_cnt_r <= h_cnt_r;
    end
  end

  // Colour selection for the current counters; the origin pixel already uses the new mode
  always_comb begin
    mode_s  = mode_q_r;
    red_s   = '0;
    green_s = '0;
    blue_s  = '0;
    if (origin_s) begin
      mode_s = mode;
    end else begin
      mode_s = mode_q_r;
    end
    if (!active_s) begin
      red_s   = '0;
      green_s = '0;
      blue_s  = '0;
    end else begin
      case (mode_s)
        2'b00: begin
          red_s   = red_in;
          green_s = green_in;
          blue_s  = blue_in;
        end
        2'b01: begin
          red_s   = {CW{~bar_idx_r[2]}};
          green_s = {CW{~bar_idx_r[1]}};
          blue_s  = {CW{~bar_idx_r[0]}};
        end
        2'b10: begin
          if (grid_s) begin
            red_s   = {CW{1'b1}};
            green_s = {CW{1'b1}};
            blue_s  = {CW{1'b1}};
          end else begin
            red_s   = '0;
            green_s = '0;
            blue_s  = '0;
          end
        end
        2'b11: begin
          if (edge_s) begin
            red_s   = {CW{1'b1}};
            green_s = {CW{1'b1}};
            blue_s  = {CW{1'b1}};
          end else begin
            red_s   = red_in;
            green_s = green_in;
            blue_s  = blue_in;
          end
        end
        default: begin
          red_s   = red_in;
          green_s = green_in;
          blue_s  = blue_in;
        end
      endcase
    end
  end

  // Output stage: registered one tick behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      de_r          <= 1'b0;
      frame_start_r <= 1'b0;
      red_r         <= '0;
      green_r       <= '0;
      blue_r        <= '0;
    end else begin
      frame_start_r <= tick_s & origin_s;
      if (tick_s) begin
        hsync_r <= hs_on_s ? HS_POL : ~HS_POL;
        vsync_r <= vs_on_s ? VS_POL : ~VS_POL;
        de_r    <= active_s;
        red_r   <= red_s;
        green_r <= green_s;
        blue_r  <= blue_s;
      end else begin
        hsync_r <= hsync_r;
      end
    end
  end

  assign x           = h_cnt_r;
  assign y           = v_cnt_r;
  assign pix_tick    = tick_s;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign de          = de_r;
  assign frame_start = frame_start_r;
  assign red         = red_r;
  assign green       = green_r;
  assign blue        = blue_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default-timing instance for line/pattern checks and a
// tiny-timing instance checked every clock against a scoreboard model across several frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default-timing instance (A)
  logic        rst_n_a;
  logic [1:0]  mode_a;
  logic [7:0]  red_in_a, green_in_a, blue_in_a;
  logic [10:0] x_a, y_a;
  logic        pix_tick_a, hsync_a, vsync_a, de_a, frame_start_a;
  logic [7:0]  red_a, green_a, blue_a;

  assign red_in_a   = x_a[7:0];
  assign green_in_a = 8'h5A;
  assign blue_in_a  = 8'hC3;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .mode(mode_a),
    .red_in(red_in_a), .green_in(green_in_a), .blue_in(blue_in_a),
    .x(x_a), .y(y_a), .pix_tick(pix_tick_a), .hsync(hsync_a), .vsync(vsync_a),
    .de(de_a), .frame_start(frame_start_a), .red(red_a), .green(green_a), .blue(blue_a)
  );

  // Tiny-timing instance (B): 12-clk lines, 7-line frames, tick every clock
  logic        rst_n_b;
  logic [1:0]  mode_b;
  logic [7:0]  red_in_b, green_in_b, blue_in_b;
  logic [10:0] x_b, y_b;
  logic        pix_tick_b, hsync_b, vsync_b, de_b, frame_start_b;
  logic [7:0]  red_b, green_b, blue_b;

  assign red_in_b   = {x_b[3:0], y_b[3:0]};
  assign green_in_b = 8'h3C;
  assign blue_in_b  = 8'h96;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .CW(8)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .mode(mode_b),
    .red_in(red_in_b), .green_in(green_in_b), .blue_in(blue_in_b),
    .x(x_b), .y(y_b), .pix_tick(pix_tick_b), .hsync(hsync_b), .vsync(vsync_b),
    .de(de_b), .frame_start(frame_start_b), .red(red_b), .green(green_b), .blue(blue_b)
  );

  typedef struct {
    logic [1:0] mode;
    int         px;
    int         py;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t        vecs[$];
  logic [49:0] sb_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic reset_a(input logic [1:0] m);
    mode_a  = m;
    rst_n_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  // Call #1 after a posedge; returns with the counters at (tx,ty) and a tick pending
  task automatic wait_pix(input int tx, input int ty, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (pix_tick_a && (int'(x_a) == tx) && (int'(y_a) == ty)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit          ok;
    int          n;
    int          cur_m;
    int          t_f1, t_r, t_f2, de_n;
    logic        prev;
    logic [10:0] mh, mv;
    logic [1:0]  mq, em;
    logic [7:0]  er, eg, eb, pr;
    logic        eact, fs, hs, vs;
    logic [49:0] ev;

    rst_n_a = 1'b0; rst_n_b = 1'b0; mode_a = 2'b00; mode_b = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", 64'({hsync_a, vsync_a, de_a, frame_start_a, pix_tick_a, red_a, green_a, blue_a, x_a, y_a}),
        64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 11'd0, 11'd0}));
    chk("reset_b", 64'({hsync_b, vsync_b, de_b, frame_start_b, pix_tick_b, red_b, x_b, y_b}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 11'd0, 11'd0}));

    // ---- Instance B: per-clock scoreboard over ~4 frames with mid-frame mode changes
    @(negedge clk);
    rst_n_b = 1'b1;
    mh = 11'd0; mv = 11'd0; mq = 2'b00;
    for (int i = 0; i < 340; i++) begin
      if (i == 30)  mode_b = 2'b01;
      if (i == 120) mode_b = 2'b10;
      if (i == 200) mode_b = 2'b11;
      if (i == 290) mode_b = 2'b00;
      eact = (mh < 11'd8) && (mv < 11'd4);
      fs   = (mh == 11'd0) && (mv == 11'd0);
      em   = fs ? mode_b : mq;
      pr   = {mh[3:0], mv[3:0]};
      er = pr; eg = 8'h3C; eb = 8'h96;
      case (em)
        2'b01: begin er = {8{~mh[2]}}; eg = {8{~mh[1]}}; eb = {8{~mh[0]}}; end
        2'b10: begin
          if (mh == 11'd0 || mv == 11'd0 || mh == 11'd7 || mv == 11'd3) begin
            er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
          end else begin
            er = 8'h00; eg = 8'h00; eb = 8'h00;
          end
        end
        2'b11: begin
          if (mh == 11'd0 || mh == 11'd7 || mv == 11'd0 || mv == 11'd3) begin
            er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
          end
        end
        default: ;
      endcase
      if (!eact) begin er = 8'h00; eg = 8'h00; eb = 8'h00; end
      if (fs) mq = mode_b;
      hs = (mh == 11'd9) || (mh == 11'd10);
      vs = (mv != 11'd5);
      if (mh == 11'd11) begin
        mh = 11'd0;
        mv = (mv == 11'd6) ? 11'd0 : mv + 11'd1;
      end else begin
        mh = mh + 11'd1;
      end
      sb_q.push_back({hs, vs, eact, fs, er, eg, eb, mh, mv});
      @(posedge clk);
      #1;
      ev = sb_q.pop_front();
      chk($sformatf("b_cyc%0d", i),
          64'({hsync_b, vsync_b, de_b, frame_start_b, red_b, green_b, blue_b, x_b, y_b}), 64'(ev));
      @(negedge clk);
    end

    // ---- Instance A: tick cadence, first pixel, line timing
    reset_a(2'b00);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (pix_tick_a) break;
    end
    chk("first_tick_latency", 64'(n), 64'(3));
    chk("pre_first_tick", 64'({x_a, y_a, de_a}), 64'({11'd0, 11'd0, 1'b0}));
    @(posedge clk);
    #1;
    chk("first_pixel", 64'({x_a, y_a, de_a, frame_start_a, hsync_a, red_a, green_a}),
        64'({11'd1, 11'd0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h5A}));
    @(posedge clk);
    #1;
    chk("frame_start_width", 64'({frame_start_a, de_a}), 64'({1'b0, 1'b1}));

    t_f1 = -1; t_r = -1; t_f2 = -1; de_n = 0; prev = hsync_a;
    for (int c = 0; c < 8000 && t_f2 < 0; c++) begin
      @(posedge clk);
      #1;
      if (prev && !hsync_a) begin
        if (t_f1 < 0) t_f1 = c;
        else t_f2 = c;
      end
      if (!prev && hsync_a && t_f1 >= 0 && t_r < 0) t_r = c;
      if (t_f1 >= 0 && t_f2 < 0 && de_a) de_n++;
      prev = hsync_a;
    end
    chk("hsync_low_clks", 64'(t_r - t_f1), 64'(384));
    chk("line_period_clks", 64'(t_f2 - t_f1), 64'(3200));
    chk("de_clks_per_line", 64'(de_n), 64'(2560));
    chk("vsync_idle_line1", 64'(vsync_a), 64'(1));

    // ---- Instance A: table-driven pattern vectors
    vecs.push_back('{2'b00,   5, 0, 1'b1, 8'h05, 8'h5A, 8'hC3});
    vecs.push_back('{2'b00, 300, 0, 1'b1, 8'h2C, 8'h5A, 8'hC3});
    vecs.push_back('{2'b00, 639, 0, 1'b1, 8'h7F, 8'h5A, 8'hC3});
    vecs.push_back('{2'b00, 640, 0, 1'b0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{2'b00, 799, 0, 1'b0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{2'b00,   0, 1, 1'b1, 8'h00, 8'h5A, 8'hC3});
    vecs.push_back('{2'b01,   0, 0, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b01,  79, 0, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b01,  80, 0, 1'b1, 8'hFF, 8'hFF, 8'h00});
    vecs.push_back('{2'b01, 160, 0, 1'b1, 8'hFF, 8'h00, 8'hFF});
    vecs.push_back('{2'b01, 320, 0, 1'b1, 8'h00, 8'hFF, 8'hFF});
    vecs.push_back('{2'b01, 639, 0, 1'b1, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{2'b01, 700, 0, 1'b0, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{2'b10,   5, 0, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b10,   0, 1, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b10,  16, 1, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b10,  17, 1, 1'b1, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{2'b10, 639, 1, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b11,   3, 0, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b11,   0, 1, 1'b1, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{2'b11,   5, 1, 1'b1, 8'h05, 8'h5A, 8'hC3});
    vecs.push_back('{2'b11, 639, 1, 1'b1, 8'hFF, 8'hFF, 8'hFF});

    cur_m = -1;
    foreach (vecs[k]) begin
      if (int'(vecs[k].mode) != cur_m) begin
        reset_a(vecs[k].mode);
        @(posedge clk);
        #1;
        cur_m = int'(vecs[k].mode);
      end
      wait_pix(vecs[k].px, vecs[k].py, ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL vec%0d_timeout: got no pixel (%0d,%0d) want it reached", k, vecs[k].px, vecs[k].py);
      end else begin
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_m%0d_x%0d_y%0d", k, vecs[k].mode, vecs[k].px, vecs[k].py),
            64'({de_a, red_a, green_a, blue_a}),
            64'({vecs[k].de, vecs[k].r, vecs[k].g, vecs[k].b}));
      end
    end

    // ---- Instance A: asynchronous reset mid-line, then restart from the origin
    reset_a(2'b00);
    @(posedge clk);
    #1;
    wait_pix(300, 1, ok);
    chk("pre_reset_active", 64'({ok, de_a, red_a}), 64'({1'b1, 1'b1, 8'h2B}));
    rst_n_a = 1'b0;
    #1;
    chk("async_reset", 64'({hsync_a, vsync_a, de_a, red_a, green_a, blue_a, x_a, y_a}),
        64'({1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 11'd0, 11'd0}));
    @(negedge clk);
    rst_n_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (pix_tick_a) begin
        ok = 1'b1;
        break;
      end
    end
    chk("restart_before_tick", 64'({ok, x_a, y_a}), 64'({1'b1, 11'd0, 11'd0}));
    @(posedge clk);
    #1;
    chk("restart_after_tick", 64'({x_a, y_a}), 64'({11'd1, 11'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
